coloring_logger: RTL and testbench

COLORING_LOGGER -- requirements
Module: coloring_logger

---
 rtl/coloring_pkg.sv | 21 ++
 rtl/color_log_fifo.sv | 79 +++++++
 rtl/coloring_logger.sv | 113 +++++++++++
 tb/tb_coloring_logger.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coloring_pkg.sv
//------------------------------------------------------------------------------
// Module : coloring_pkg
// Brief  : Colour encodings and log entry sizing shared by the coloring logger.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package coloring_pkg;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;

    // A log entry is {sample index, colour}
    function automatic int entry_w(input int idx_w);
        return idx_w + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/color_log_fifo.sv
//------------------------------------------------------------------------------
// Module : color_log_fifo
// Brief  : Synchronous FIFO with a registered head-entry output and full/empty.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module color_log_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_head;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW:0]   w_left;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

    always_comb begin
        w_pop        = pop & ~empty;
        w_push       = push & (~full | w_pop);
        w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
        w_left       = r_count - (AW+1)'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push && !clr)
            r_mem[r_wr_ptr] <= wdata;
    end

    // The head register preloads whatever will sit at the read pointer next,
    // taking the incoming word when it lands in an otherwise empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push && (w_left == '0))
                r_head <= wdata;
            else if (w_left != '0)
                r_head <= r_mem[w_rd_ptr_nxt];
        end
    end

    assign rd_data = r_head;

endmodule

`default_nettype wire

// File: rtl/coloring_logger.sv
//------------------------------------------------------------------------------
// Module : coloring_logger
// Brief  : Logs {index, colour} of samples flagged by an upstream checker.
//          Optional sticky overflow flag: define COLORING_LOGGER_OVF_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module coloring_logger
    import coloring_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         color,
    input  logic               check,
    input  logic               clr,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [IDX_W+1:0]   rd_data,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic               ovf
);

    localparam int EW = entry_w(IDX_W);

    logic [1:0]       r_color;
    logic [IDX_W-1:0] r_idx;
    logic             r_primed;
    logic [CNT_W-1:0] r_viol;

    logic             w_cand;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [EW-1:0]    w_entry;

    // r_idx counts samples taken, so the sample held in r_color is r_idx-1
    assign w_cand  = r_primed & check;
    assign w_entry = {r_idx - IDX_W'(1), r_color};
    assign w_pop   = rd_ready & ~w_empty;
    assign w_push  = w_cand & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color  <= RED;
            r_idx    <= '0;
            r_primed <= 1'b0;
        end else if (clr) begin
            r_color  <= color;
            r_idx    <= '0;
            r_primed <= 1'b0;
        end else begin
            r_color  <= color;
            r_idx    <= r_idx + IDX_W'(1);
            r_primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_viol <= '0;
        else if (clr)
            r_viol <= '0;
        else if (w_cand && (r_viol != '1))
            r_viol <= r_viol + CNT_W'(1);
    end

`ifdef COLORING_LOGGER_OVF_EN
    logic r_ovf;
    logic w_drop;

    assign w_drop = w_cand & ~w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (clr)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    color_log_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (w_entry),
        .rd_data (rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign rd_valid = ~w_empty;
    assign viol_cnt = r_viol;

endmodule

`default_nettype wire

// File: tb/tb_coloring_logger.sv
//------------------------------------------------------------------------------
// Module : tb_coloring_logger
// Brief  : Self-checking bench for coloring_logger against a queue-based model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_coloring_logger;

    localparam int DEPTH = 8;
    localparam int IDX_W = 8;
    localparam int CNT_W = 8;
`ifdef COLORING_LOGGER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       color;
    logic             check;
    logic             clr;
    logic             rd_ready;
    logic             rd_valid;
    logic [IDX_W+1:0] rd_data;
    logic [CNT_W-1:0] viol_cnt;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    // Reference model: samples numbered from 0 since reset/clr, log is a queue
    logic [IDX_W+1:0] m_q[$];
    int               m_nsamp;
    logic [1:0]       m_last;
    bit               m_primed;
    int               m_viol;
    bit               m_ovf;

    always #5 clk = ~clk;

    coloring_logger #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .color    (color),
        .check    (check),
        .clr      (clr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .viol_cnt (viol_cnt),
        .ovf      (ovf)
    );

    task automatic model_reset();
        m_q.delete();
        m_nsamp  = 0;
        m_last   = 2'd0;
        m_primed = 1'b0;
        m_viol   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        logic [IDX_W+1:0] tmp;
        if (clr) begin
            model_reset();
            return;
        end
        if (rd_ready && m_q.size() > 0)
            tmp = m_q.pop_front();
        if (m_primed && check) begin
            if (m_viol < 255)
                m_viol = m_viol + 1;
            if (m_q.size() < DEPTH)
                m_q.push_back({IDX_W'(m_nsamp - 1), m_last});
            else if (OVF_EN)
                m_ovf = 1'b1;
        end
        m_last   = color;
        m_nsamp  = m_nsamp + 1;
        m_primed = 1'b1;
    endtask

    // One clock: inputs were set after the previous falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; color = 2'd0; check = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        total++;
        if (rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data); end
        total++;
        if (viol_cnt !== '0) begin bad++; $display("FAIL reset_viol got=%0d exp=0", viol_cnt); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        color = 2'd1;
        repeat (3) cyc();
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%b exp=0", rd_valid); end
        check = 1'b1;
        cyc();
        check = 1'b0;
        total++;
        if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
        total++;
        if (rd_data !== {8'd2, 2'd1}) begin bad++; $display("FAIL basic_data got=%h exp=%h", rd_data, {8'd2, 2'd1}); end
        total++;
        if (viol_cnt !== 8'd1) begin bad++; $display("FAIL basic_viol got=%0d exp=1", viol_cnt); end
    endtask

    task automatic test_overflow();
        clr = 1'b1; cyc(); clr = 1'b0;
        rd_ready = 1'b0; check = 1'b0;
        color = 2'($urandom_range(0, 2));
        cyc();
        check = 1'b1;
        for (int i = 0; i < 9; i++) begin
            color = 2'($urandom_range(0, 3));
            cyc();
        end
        check = 1'b0;
        total++;
        if (viol_cnt !== 8'd9) begin bad++; $display("FAIL ovf_viol got=%0d exp=9", viol_cnt); end
        total++;
        if (ovf !== OVF_EN) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ovf, OVF_EN); end
        total++;
        if (m_q.size() != DEPTH || rd_data !== m_q[0] || rd_data[9:2] !== 8'd0) begin
            bad++; $display("FAIL ovf_head got=%h exp=%h", rd_data, m_q[0]);
        end
    endtask

    task automatic test_full_push_pop();
        logic ovf_before;
        int   popped;
        ovf_before = ovf;
        rd_ready = 1'b1; check = 1'b1; color = 2'd2;
        cyc();
        check = 1'b0;
        total++;
        if (rd_data[9:2] !== 8'd1 || rd_data !== m_q[0]) begin
            bad++; $display("FAIL fpp_head got=%h exp=%h", rd_data, m_q[0]);
        end
        total++;
        if (ovf !== ovf_before) begin bad++; $display("FAIL fpp_ovf got=%b exp=%b", ovf, ovf_before); end
        total++;
        if (viol_cnt !== 8'd10) begin bad++; $display("FAIL fpp_viol got=%0d exp=10", viol_cnt); end
        popped = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (rd_valid === 1'b1) begin
                popped++;
                total++;
                if (rd_data !== m_q[0]) begin bad++; $display("FAIL fpp_drain i=%0d got=%h exp=%h", i, rd_data, m_q[0]); end
                if (popped == DEPTH) begin
                    total++;
                    if (rd_data[9:2] !== 8'd9) begin bad++; $display("FAIL fpp_newest got=%0d exp=9", rd_data[9:2]); end
                end
            end
            cyc();
        end
        total++;
        if (popped != DEPTH) begin bad++; $display("FAIL fpp_occupancy got=%0d exp=%0d", popped, DEPTH); end
        rd_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [1:0] c255;
        clr = 1'b1; cyc(); clr = 1'b0;
        rd_ready = 1'b0;
        for (int e = 1; e <= 258; e++) begin
            color = 2'($urandom_range(0, 2));
            check = (e == 257 || e == 258);
            cyc();
        end
        check = 1'b0;
        c255 = m_q[0][1:0];
        total++;
        if (rd_valid !== 1'b1 || rd_data[9:2] !== 8'd255 || rd_data[1:0] !== c255) begin
            bad++; $display("FAIL wrap_first got=%h exp_idx=255", rd_data);
        end
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data[9:2] !== 8'd0 || rd_data !== m_q[0]) begin
            bad++; $display("FAIL wrap_second got=%h exp=%h", rd_data, m_q[0]);
        end
    endtask

    task automatic test_saturate();
        clr = 1'b1; cyc(); clr = 1'b0;
        rd_ready = 1'b1; check = 1'b1;
        repeat (300) begin
            color = 2'($urandom_range(0, 3));
            cyc();
        end
        check = 1'b0; rd_ready = 1'b0;
        total++;
        if (viol_cnt !== 8'd255 || m_viol != 255) begin bad++; $display("FAIL sat_viol got=%0d exp=255", viol_cnt); end
    endtask

    task automatic test_clr();
        check = 1'b1; rd_ready = 1'b0;
        repeat (3) cyc();
        clr = 1'b1; rd_ready = 1'b1;
        cyc();
        clr = 1'b0; rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", rd_valid); end
        total++;
        if (viol_cnt !== '0 || ovf !== 1'b0) begin bad++; $display("FAIL clr_cnt got=%0d/%b exp=0/0", viol_cnt, ovf); end
        cyc();
        check = 1'b0;
        cyc();
        total++;
        if (rd_valid !== 1'b0 || viol_cnt !== '0) begin
            bad++; $display("FAIL clr_unprimed got=%b/%0d exp=0/0", rd_valid, viol_cnt);
        end
    endtask

    task automatic test_async_reset();
        check = 1'b1; rd_ready = 1'b0;
        repeat (3) cyc();
        check = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b0 || viol_cnt !== '0) begin
            bad++; $display("FAIL arst_immediate got=%b/%0d exp=0/0", rd_valid, viol_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        color = 2'd2;
        repeat (5) cyc();
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL arst_empty got=%b exp=0", rd_valid); end
        check = 1'b1; cyc(); check = 1'b0;
        total++;
        if (rd_data !== {8'd4, 2'd2} || rd_data !== m_q[0]) begin
            bad++; $display("FAIL arst_restart got=%h exp=%h", rd_data, {8'd4, 2'd2});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            color    = 2'($urandom_range(0, 3));
            check    = ($urandom_range(0, 99) < 55);
            rd_ready = ($urandom_range(0, 99) < 40);
            clr      = ($urandom_range(0, 99) == 0);
            cyc();
            total++;
            if (rd_valid !== (m_q.size() != 0)) begin
                bad++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, rd_valid, m_q.size() != 0);
            end else if (rd_valid && rd_data !== m_q[0]) begin
                bad++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, rd_data, m_q[0]);
            end
            total++;
            if (viol_cnt !== CNT_W'(m_viol) || ovf !== m_ovf) begin
                bad++; $display("FAIL rand_cnt i=%0d got=%0d/%b exp=%0d/%b", i, viol_cnt, ovf, m_viol, m_ovf);
            end
        end
        clr = 1'b0; check = 1'b0; rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_saturate();
        test_clr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
